accumulator_datapath: RTL and testbench
=======================================

# accumulator_datapath

Datapath stage driven by the processor's control state machine: it decodes the 5-bit control word each cycle, holds the operand (B) and accumulator (ACC) registers, performs load/add/subtract/shift, and returns a registered 2-bit status `vz` (overflow, zero) that the controller uses for its next-state decisions. All state updates occur on the rising clock edge, so there is no combinational path from `ctrl` to `vz`.

## Interface
- `WIDTH`, default 8: data width of `data_in`, B, ACC and `acc_out`; minimum 2.
- `clock`  input  1  single system clock; all state changes on the rising edge.
- `clear`  input  1  reset; asynchronous, active-low; forces every register to its reset value.
- `ctrl`  input  5  control word from the controller: [4:3] op, [2] acc_en, [1] b_en, [0] flag_en.
- `data_in`  input  WIDTH  operand source, captured into B when b_en=1.
- `acc_out`  output  WIDTH  ACC register contents.
- `b_out`  output  WIDTH  B register contents, for debug and observation.
- `vz`  output  2  registered status: vz[1]=V (signed overflow), vz[0]=Z (result zero).

## Operation
- Op decode, ctrl[4:3]. Each op produces a combinational result R:
  - 00 LOAD: R=B, V=0.
  - 01 ADD: R=ACC+B mod 2^WIDTH; V=1 when both operands have equal sign bits and R's sign bit differs.
  - 10 SUB: R=ACC−B mod 2^WIDTH; V=1 when the operand signs differ and R's sign bit differs from ACC's.
  - 11 SHL: R={ACC[WIDTH-2:0],0}; V=ACC[WIDTH-1] xor ACC[WIDTH-2].
- Z=1 exactly when R is all zeros.
- acc_en=1: ACC<=R. acc_en=0: ACC holds.
- b_en=1: B<=data_in. b_en=0: B holds.
  - When b_en and acc_en are both set in the same cycle, the ALU uses the old B. The new B is visible from the next cycle.
- flag_en=1: vz<={V,Z}, computed from R whether or not acc_en is set. This allows a compare: SUB with acc_en=0.
- flag_en=0: vz holds its previous value.
- Arithmetic is unsigned-modular for R and signed two's complement for V. There is no carry output; carry out of the MSB is discarded.
- ctrl=5'b00000 is a NOP: all registers hold.
- All 32 ctrl codes are legal. There are no undefined states.

## Timing
- Reset (clear=0, asynchronous): ACC=0, B=0, vz=2'b00, held while clear=0.
- Reset release: the first update happens on the first rising edge with clear=1.
- Assertion mid-operation: clear=0 at any point, including mid-cycle, zeroes all outputs immediately and discards any in-flight op.
- Latency: a `ctrl`/`data_in` value sampled at edge N is visible on acc_out/b_out/vz after edge N.
  - Back-to-back ops are supported every cycle: the op at edge N+1 sees ACC from edge N.
- vz reflects the last flag-enabled op. The controller samples vz in the cycle after that op.
- The block requires no handshake. The controller guarantees that `ctrl` is stable before each rising edge.

## Structure
- Shared package `accumulator_pkg` holds:
  - op constants OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_SHL=2'b11;
  - ctrl bit indices CTRL_ACC_EN=2, CTRL_B_EN=1, CTRL_FLAG_EN=0;
  - vz indices VZ_V=1, VZ_Z=0.
  - The controller and this block both use the package.
- One sub-module, `accumulator_alu`: purely combinational; inputs op, ACC, B; outputs R, V, Z.
- The top level holds the three registers and the enable logic.

## Test plan
All scenarios use WIDTH=8.
- Reset:
  - Stimulus: drive clear=0 mid-cycle after ACC=8'h5A.
  - Required: acc_out=0, b_out=0, vz=00 immediately, with no clock edge.
  - Stimulus: release clear with ctrl=NOP.
  - Required: all outputs stay 0.
- Load then add:
  - Stimulus: data_in=8'h03 with b_en, acc_en, op LOAD.
  - Required: ACC=8'h00, because the old B is used; B=8'h03.
  - Stimulus: next cycle, LOAD with acc_en.
  - Required: ACC=8'h03.
  - Stimulus: ADD with flag_en.
  - Required: ACC=8'h06, vz=00.
- Signed overflow: ACC=8'h7F, B=8'h01, ADD with flag_en -> ACC=8'h80, vz=2'b10. ACC=8'h80, B=8'h01, SUB with flag_en -> ACC=8'h7F, vz=2'b10.
- Compare without write: ACC=8'h22, B=8'h22, SUB with acc_en=0 and flag_en=1 -> ACC stays 8'h22, vz=2'b01.
- Shift and zero: ACC=8'h80, SHL with acc_en and flag_en -> ACC=8'h00, vz=2'b11. ACC=8'h40, SHL -> ACC=8'h80, V=1.
- Flag hold: after vz=01, run an ADD with flag_en=0 producing a nonzero result -> vz stays 01 and ACC updates.

Source files
------------

// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_pkg
// Description : Shared op codes and ctrl/vz bit positions for the accumulator
//               datapath and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
package accumulator_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam int CTRL_ACC_EN  = 2;
  localparam int CTRL_B_EN    = 1;
  localparam int CTRL_FLAG_EN = 0;

  localparam int VZ_V = 1;
  localparam int VZ_Z = 0;

  function automatic logic [1:0] ctrl_op(input logic [4:0] ctrl);
    return ctrl[4:3];
  endfunction

endpackage : accumulator_pkg
`default_nettype wire

// File: rtl/accumulator_alu.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_alu
// Description : Combinational load/add/sub/shift unit producing result R and
//               signed-overflow (V) / zero (Z) status.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_alu
  import accumulator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             v,
  output logic             z
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    r = '0;
    v = 1'b0;
    case (op)
      OP_LOAD: begin
        r = b;
      end
      OP_ADD: begin
        r = acc + b;
        v = (acc[MSB] == b[MSB]) && (r[MSB] != acc[MSB]);
      end
      OP_SUB: begin
        r = acc - b;
        v = (acc[MSB] != b[MSB]) && (r[MSB] != acc[MSB]);
      end
      OP_SHL: begin
        r = {acc[WIDTH-2:0], 1'b0};
        // Sign changes exactly when the two top bits disagree.
        v = acc[MSB] ^ acc[WIDTH-2];
      end
      default: begin
        r = '0;
        v = 1'b0;
      end
    endcase
  end

  assign z = (r == '0);

endmodule : accumulator_alu
`default_nettype wire

// File: rtl/accumulator_datapath.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_datapath
// Description : Operand (B), accumulator (ACC) and registered status (vz)
//               registers driven by a 5-bit control word from the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_datapath
  import accumulator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] b_out,
  output logic [1:0]       vz
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_vz;

  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_r;
  logic             w_v;
  logic             w_z;

  assign w_op = ctrl_op(ctrl);

  // The ALU always sees the registered B, so a same-cycle B load is not used.
  accumulator_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op  (w_op),
    .acc (r_acc),
    .b   (r_b),
    .r   (w_r),
    .v   (w_v),
    .z   (w_z)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_acc <= '0;
      r_b   <= '0;
      r_vz  <= 2'b00;
    end else begin
      if (ctrl[CTRL_ACC_EN]) begin
        r_acc <= w_r;
      end
      if (ctrl[CTRL_B_EN]) begin
        r_b <= data_in;
      end
      if (ctrl[CTRL_FLAG_EN]) begin
        r_vz[VZ_V] <= w_v;
        r_vz[VZ_Z] <= w_z;
      end
    end
  end

  assign acc_out = r_acc;
  assign b_out   = r_b;
  assign vz      = r_vz;

endmodule : accumulator_datapath
`default_nettype wire

// File: tb/tb_accumulator_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_datapath
// Description : Scoreboard bench for accumulator_datapath with an arithmetic
//               reference model and randomized plus directed control words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_datapath;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] b;
    logic [1:0] vz;
  } exp_t;

  logic       clk;
  logic       clear;
  logic [4:0] ctrl;
  logic [7:0] data_in;
  logic [7:0] acc_out;
  logic [7:0] b_out;
  logic [1:0] vz;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  int       m_acc;
  int       m_b;
  logic [1:0] m_vz;

  accumulator_datapath #(
    .WIDTH (WIDTH)
  ) dut (
    .clock   (clk),
    .clear   (clear),
    .ctrl    (ctrl),
    .data_in (data_in),
    .acc_out (acc_out),
    .b_out   (b_out),
    .vz      (vz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] mk(input int op, input bit a, input bit bb, input bit f);
    logic [1:0] o;
    o = op[1:0];
    return {o, a, bb, f};
  endfunction

  function automatic int to_signed(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: signed results computed as integers, overflow = out of range.
  task automatic step(input logic [4:0] c, input logic [7:0] d);
    int s;
    int r;
    bit v;
    exp_t e;
    @(negedge clk);
    ctrl    = c;
    data_in = d;
    s = 0;
    r = 0;
    v = 1'b0;
    case (int'(c[4:3]))
      0: begin r = m_b; end
      1: begin s = to_signed(m_acc) + to_signed(m_b); r = (m_acc + m_b) % 256; v = (s > 127) || (s < -128); end
      2: begin s = to_signed(m_acc) - to_signed(m_b); r = (m_acc - m_b + 256) % 256; v = (s > 127) || (s < -128); end
      default: begin s = to_signed(m_acc) * 2; r = (m_acc * 2) % 256; v = (s > 127) || (s < -128); end
    endcase
    if (c[0]) m_vz = {v, (r == 0)};
    if (c[2]) m_acc = r;
    if (c[1]) m_b = int'(d);
    e.acc = m_acc[7:0];
    e.b   = m_b[7:0];
    e.vz  = m_vz;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [17:0] act, input logic [17:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: acc/b/vz actual=%h/%h/%b required=%h/%h/%b",
               name, act[17:10], act[9:2], act[1:0], req[17:10], req[9:2], req[1:0]);
    end
  endtask

  // Monitor: one expected entry per clock edge while the scoreboard is loaded.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({acc_out, b_out, vz} !== {e.acc, e.b, e.vz}) begin
          bad++;
          $display("FAIL scoreboard t=%0t ctrl=%b: acc/b/vz actual=%h/%h/%b required=%h/%h/%b",
                   $time, ctrl, acc_out, b_out, vz, e.acc, e.b, e.vz);
        end
      end
    end
  end

  initial begin
    int waited;
    clear   = 1'b1;
    ctrl    = 5'b0;
    data_in = 8'h00;
    m_acc = 0;
    m_b   = 0;
    m_vz  = 2'b00;
    #2 clear = 1'b0;
    #1 check_now("power_on_reset", {acc_out, b_out, vz}, 18'h0);
    @(negedge clk);
    clear = 1'b1;

    // Mid-cycle asynchronous clear after ACC=5A.
    step(mk(0, 0, 1, 0), 8'h5A);
    step(mk(0, 1, 0, 1), 8'h00);
    @(posedge clk);
    #3;
    clear = 1'b0;
    #1 check_now("async_clear", {acc_out, b_out, vz}, 18'h0);
    m_acc = 0;
    m_b   = 0;
    m_vz  = 2'b00;
    ctrl    = 5'b11111;
    data_in = 8'hFF;
    @(posedge clk);
    #1 check_now("clear_held", {acc_out, b_out, vz}, 18'h0);
    @(negedge clk);
    ctrl  = 5'b0;
    clear = 1'b1;
    step(5'b00000, 8'hFF);

    // Load then add: the same-cycle B load is not seen by the ALU.
    step(mk(0, 1, 1, 0), 8'h03);
    step(mk(0, 1, 0, 0), 8'h00);
    step(mk(1, 1, 0, 1), 8'h00);
    // Signed overflow on ADD and SUB.
    step(mk(0, 0, 1, 0), 8'h7F);
    step(mk(0, 1, 1, 0), 8'h01);
    step(mk(1, 1, 0, 1), 8'h00);
    step(mk(2, 1, 0, 1), 8'h00);
    // Compare without write, then flag hold.
    step(mk(0, 0, 1, 0), 8'h22);
    step(mk(0, 1, 0, 0), 8'h00);
    step(mk(2, 0, 0, 1), 8'h00);
    step(mk(1, 1, 0, 0), 8'h00);
    // Shift to zero and shift into the sign bit.
    step(mk(0, 0, 1, 0), 8'h80);
    step(mk(0, 1, 0, 0), 8'h00);
    step(mk(3, 1, 0, 1), 8'h00);
    step(mk(0, 0, 1, 0), 8'h40);
    step(mk(0, 1, 0, 0), 8'h00);
    step(mk(3, 1, 0, 1), 8'h00);
    step(5'b00000, 8'hAA);

    for (int i = 0; i < 300; i++) begin
      step(5'($urandom_range(0, 31)), 8'($urandom));
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_accumulator_datapath
`default_nettype wire
